// File: rtl/spi_config_rx.sv
// SPI mode-0 configuration receiver: captures a FRAME_BITS-bit word over SPI and
// commits it to cfg on the next sample_tick; reports link status back on MISO.
module spi_config_rx #(
  parameter int FRAME_BITS  = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  sample_tick,
  input  logic                  spi_clk,
  input  logic                  spi_mosi,
  input  logic                  spi_csn,
  output logic                  spi_miso,
  output logic [FRAME_BITS-1:0] cfg,
  output logic                  cfg_valid,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int CNT_W = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, csn_sync_q;
  logic                   sclk_prev_q, csn_prev_q;
  logic                   sclk_s, mosi_s, csn_s;
  logic                   sclk_rise, sclk_fall, csn_rise, csn_fall;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       bitcnt_q, bitcnt_d;
  logic [FRAME_BITS-1:0]  shift_q, shift_d;
  logic [FRAME_BITS-1:0]  shadow_q, shadow_d;
  logic [FRAME_BITS-1:0]  cfg_q, cfg_d;
  logic                   pending_q, pending_d;
  logic                   cfg_valid_q, cfg_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;
  logic [7:0]             miso_q, miso_d;
  logic                   fall_hold_q, fall_hold_d;

  // Edges are derived only from the last synchroniser stage and its delayed copy.
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign csn_s     = csn_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign csn_rise  = csn_s & ~csn_prev_q;
  assign csn_fall  = ~csn_s & csn_prev_q;

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    shadow_d    = shadow_q;
    cfg_d       = cfg_q;
    pending_d   = pending_q;
    cfg_valid_d = 1'b0;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
    miso_d      = miso_q;
    fall_hold_d = fall_hold_q;

    // The commit sees the registered pending/shadow, so a frame finishing
    // CHECK on the same edge is only committed by a later tick.
    if (sample_tick && pending_q) begin
      cfg_d       = shadow_q;
      cfg_valid_d = 1'b1;
      pending_d   = 1'b0;
    end

    case (state_q)
      IDLE: begin
        fall_hold_d = 1'b0;
        if (csn_fall || fall_hold_q) begin
          state_d     = SHIFT;
          bitcnt_d    = '0;
          miso_d      = {5'b10100, pending_q, overrun_q, frame_err_q};
          frame_err_d = 1'b0;
          overrun_d   = 1'b0;
        end
      end
      SHIFT: begin
        if (sclk_rise) begin
          shift_d = {mosi_s, shift_q[FRAME_BITS-1:1]};
          if (bitcnt_q != CNT_SAT) bitcnt_d = bitcnt_q + CNT_W'(1);
        end
        if (sclk_fall) miso_d = {1'b0, miso_q[7:1]};
        if (csn_rise) begin
          state_d = CHECK;
          miso_d  = '0;
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (csn_fall) fall_hold_d = 1'b1;
        if (bitcnt_q == CNT_FULL) begin
          shadow_d  = shift_q;
          pending_d = 1'b1;
          if (pending_q) overrun_d = 1'b1;
        end else begin
          frame_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      csn_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
      csn_prev_q  <= 1'b0;
      state_q     <= IDLE;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      shadow_q    <= '0;
      cfg_q       <= '0;
      pending_q   <= 1'b0;
      cfg_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      miso_q      <= '0;
      fall_hold_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], spi_csn};
      sclk_prev_q <= sclk_s;
      csn_prev_q  <= csn_s;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      shadow_q    <= shadow_d;
      cfg_q       <= cfg_d;
      pending_q   <= pending_d;
      cfg_valid_q <= cfg_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      miso_q      <= miso_d;
      fall_hold_q <= fall_hold_d;
    end
  end

  assign spi_miso  = miso_q[0];
  assign cfg       = cfg_q;
  assign cfg_valid = cfg_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_spi_config_rx.sv
// Testbench for spi_config_rx with FRAME_BITS=64 against a frame-level reference model.
module tb_spi_config_rx;

  localparam int FB = 64;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          sample_tick = 1'b0;
  logic          spi_clk = 1'b0;
  logic          spi_mosi = 1'b0;
  logic          spi_csn = 1'b1;
  logic          spi_miso;
  logic [FB-1:0] cfg;
  logic          cfg_valid, frame_err, overrun;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state: what the block should hold, in frame/tick terms.
  logic          m_pend;
  logic [63:0]   m_shadow, m_cfg;
  logic          m_ferr, m_ovr;

  spi_config_rx #(.FRAME_BITS(FB), .SYNC_STAGES(2)) dut (
    .clk(clk), .rstn(rstn), .sample_tick(sample_tick),
    .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_csn(spi_csn),
    .spi_miso(spi_miso), .cfg(cfg), .cfg_valid(cfg_valid),
    .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pend = 1'b0; m_shadow = '0; m_cfg = '0; m_ferr = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic model_start(output logic [7:0] st);
    st = {5'b10100, m_pend, m_ovr, m_ferr};
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
  endtask

  task automatic model_end(input logic [127:0] d, input int n);
    if (n == FB) begin
      if (m_pend) m_ovr = 1'b1;
      m_shadow = d[63:0];
      m_pend   = 1'b1;
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  task automatic model_tick(output logic ev);
    ev = m_pend;
    if (m_pend) begin
      m_cfg  = m_shadow;
      m_pend = 1'b0;
    end
  endtask

  task automatic csn_fall();
    @(negedge clk);
    spi_csn = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_bits(input logic [127:0] d, input int n, output logic [15:0] rd);
    rd = '0;
    for (int i = 0; i < n; i++) begin
      spi_mosi = d[i];
      repeat (4) @(negedge clk);
      if (i < 16) rd[i] = spi_miso;
      spi_clk = 1'b1;
      repeat (4) @(negedge clk);
      spi_clk = 1'b0;
    end
  endtask

  // With coincide set, sample_tick is raised so that it lands on the CHECK cycle.
  task automatic csn_rise(input bit coincide, output logic v_at);
    repeat (4) @(negedge clk);
    spi_csn = 1'b1;
    v_at = 1'b0;
    if (coincide) begin
      repeat (3) @(negedge clk);
      sample_tick = 1'b1;
      @(posedge clk);
      #1 v_at = cfg_valid;
      @(negedge clk);
      sample_tick = 1'b0;
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic do_frame(input logic [127:0] d, input int n, input bit coincide,
                          output logic [15:0] rd, output logic v_at);
    csn_fall();
    send_bits(d, n, rd);
    csn_rise(coincide, v_at);
  endtask

  task automatic pulse_tick(output logic v_pre, output logic v_on,
                            output logic [63:0] c_on, output logic v_post);
    @(negedge clk);
    v_pre = cfg_valid;
    sample_tick = 1'b1;
    @(posedge clk);
    #1;
    v_on = cfg_valid;
    c_on = cfg;
    @(negedge clk);
    sample_tick = 1'b0;
    @(posedge clk);
    #1 v_post = cfg_valid;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({cfg, cfg_valid, frame_err, overrun, spi_miso} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got cfg=%h v=%b fe=%b ov=%b miso=%b, required all 0",
               cfg, cfg_valid, frame_err, overrun, spi_miso);
    end
    rstn = 1'b1;
    model_reset();
    repeat (6) @(negedge clk);
    n_cmp++;
    if (frame_err !== 1'b0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_flags: got fe=%b ov=%b, required 0 0", frame_err, overrun);
    end
  endtask

  task automatic test_valid_frame();
    logic [7:0] st; logic [15:0] rd; logic v_at, ev, v_pre, v_on, v_post; logic [63:0] c_on;
    logic [127:0] d;
    d = {64'h0, 64'h0123456789ABCDEF};
    model_start(st);
    do_frame(d, 64, 1'b0, rd, v_at);
    model_end(d, 64);
    n_cmp++;
    if (rd !== {8'h00, st}) begin
      n_fail++; $display("FAIL valid_status: got %h required %h", rd, {8'h00, st});
    end
    n_cmp++;
    if (cfg !== m_cfg) begin
      n_fail++; $display("FAIL valid_cfg_before_tick: got %h required %h", cfg, m_cfg);
    end
    pulse_tick(v_pre, v_on, c_on, v_post);
    model_tick(ev);
    n_cmp++;
    if ({v_pre, v_on, v_post} !== {1'b0, ev, 1'b0}) begin
      n_fail++; $display("FAIL valid_pulse: got %b%b%b required 0%b0", v_pre, v_on, v_post, ev);
    end
    n_cmp++;
    if (c_on !== 64'h0123456789ABCDEF) begin
      n_fail++; $display("FAIL valid_cfg: got %h required 0123456789abcdef", c_on);
    end
  endtask

  task automatic test_short_frame();
    logic [7:0] st; logic [15:0] rd; logic v_at, ev, v_pre, v_on, v_post; logic [63:0] c_on;
    logic [127:0] d;
    d = {$urandom, $urandom, $urandom, $urandom};
    model_start(st);
    do_frame(d, 63, 1'b0, rd, v_at);
    model_end(d, 63);
    n_cmp++;
    if (frame_err !== 1'b1) begin
      n_fail++; $display("FAIL short_frame_err: got %b required 1", frame_err);
    end
    pulse_tick(v_pre, v_on, c_on, v_post);
    model_tick(ev);
    n_cmp++;
    if (v_on !== 1'b0 || c_on !== m_cfg) begin
      n_fail++; $display("FAIL short_no_commit: got v=%b cfg=%h required v=0 cfg=%h", v_on, c_on, m_cfg);
    end
    d = {$urandom, $urandom, $urandom, $urandom};
    model_start(st);
    csn_fall();
    n_cmp++;
    if (frame_err !== 1'b0) begin
      n_fail++; $display("FAIL short_err_cleared: got %b required 0", frame_err);
    end
    send_bits(d, 64, rd);
    csn_rise(1'b0, v_at);
    model_end(d, 64);
    n_cmp++;
    if (rd !== 16'h00A1 || rd[7:0] !== st) begin
      n_fail++; $display("FAIL short_status: got %h required 00a1 (model %h)", rd, st);
    end
    pulse_tick(v_pre, v_on, c_on, v_post);
    model_tick(ev);
    n_cmp++;
    if (v_on !== ev || c_on !== m_cfg) begin
      n_fail++; $display("FAIL short_next_commit: got v=%b cfg=%h required v=%b cfg=%h", v_on, c_on, ev, m_cfg);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] st; logic [15:0] rd; logic v_at, ev, v_pre, v_on, v_post; logic [63:0] c_on;
    logic [127:0] a, b;
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    model_start(st);
    do_frame(a, 64, 1'b0, rd, v_at);
    model_end(a, 64);
    model_start(st);
    do_frame(b, 64, 1'b0, rd, v_at);
    model_end(b, 64);
    n_cmp++;
    if (rd[7:0] !== st) begin
      n_fail++; $display("FAIL overrun_status_pending: got %h required %h", rd[7:0], st);
    end
    n_cmp++;
    if (overrun !== 1'b1 || frame_err !== 1'b0) begin
      n_fail++; $display("FAIL overrun_flag: got ov=%b fe=%b required 1 0", overrun, frame_err);
    end
    pulse_tick(v_pre, v_on, c_on, v_post);
    model_tick(ev);
    n_cmp++;
    if (v_on !== 1'b1 || c_on !== b[63:0]) begin
      n_fail++; $display("FAIL overrun_commit_b: got v=%b cfg=%h required v=1 cfg=%h", v_on, c_on, b[63:0]);
    end
  endtask

  task automatic test_coincide();
    logic [7:0] st; logic [15:0] rd; logic v_at, ev, v_pre, v_on, v_post; logic [63:0] c_on;
    logic [127:0] d;
    d = {$urandom, $urandom, $urandom, $urandom};
    model_start(st);
    do_frame(d, 64, 1'b1, rd, v_at);
    model_tick(ev);
    model_end(d, 64);
    n_cmp++;
    if (v_at !== ev || cfg !== m_cfg) begin
      n_fail++; $display("FAIL coincide_no_commit: got v=%b cfg=%h required v=%b cfg=%h", v_at, cfg, ev, m_cfg);
    end
    pulse_tick(v_pre, v_on, c_on, v_post);
    model_tick(ev);
    n_cmp++;
    if (v_on !== 1'b1 || c_on !== d[63:0]) begin
      n_fail++; $display("FAIL coincide_next_tick: got v=%b cfg=%h required v=1 cfg=%h", v_on, c_on, d[63:0]);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] st; logic [15:0] rd; logic v_at, ev, v_pre, v_on, v_post; logic [63:0] c_on;
    logic [127:0] d;
    d = {$urandom, $urandom, $urandom, $urandom};
    csn_fall();
    send_bits(d, 30, rd);
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({cfg, cfg_valid, frame_err, overrun, spi_miso} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got cfg=%h v=%b fe=%b ov=%b miso=%b, required all 0",
               cfg, cfg_valid, frame_err, overrun, spi_miso);
    end
    rstn = 1'b1;
    model_reset();
    send_bits(d, 40, rd);
    for (int k = 0; k < 2; k++) begin
      pulse_tick(v_pre, v_on, c_on, v_post);
      model_tick(ev);
      n_cmp++;
      if (v_on !== ev || c_on !== m_cfg) begin
        n_fail++; $display("FAIL midreset_no_commit: got v=%b cfg=%h required v=%b cfg=%h", v_on, c_on, ev, m_cfg);
      end
    end
    spi_csn = 1'b1;
    repeat (8) @(negedge clk);
    n_cmp++;
    if (frame_err !== m_ferr || overrun !== m_ovr) begin
      n_fail++; $display("FAIL midreset_csn_rise_ignored: got fe=%b ov=%b required %b %b", frame_err, overrun, m_ferr, m_ovr);
    end
    d = {$urandom, $urandom, $urandom, $urandom};
    model_start(st);
    do_frame(d, 64, 1'b0, rd, v_at);
    model_end(d, 64);
    pulse_tick(v_pre, v_on, c_on, v_post);
    model_tick(ev);
    n_cmp++;
    if (v_on !== 1'b1 || c_on !== d[63:0] || rd[7:0] !== st) begin
      n_fail++; $display("FAIL midreset_fresh_frame: got v=%b cfg=%h st=%h required v=1 cfg=%h st=%h",
                         v_on, c_on, rd[7:0], d[63:0], st);
    end
  endtask

  task automatic test_long_frame();
    logic [7:0] st; logic [15:0] rd; logic v_at, ev, v_pre, v_on, v_post; logic [63:0] c_on;
    logic [127:0] a, e;
    a = {$urandom, $urandom, $urandom, $urandom};
    e = {$urandom, $urandom, $urandom, $urandom};
    model_start(st);
    do_frame(a, 64, 1'b0, rd, v_at);
    model_end(a, 64);
    model_start(st);
    do_frame(e, 65, 1'b0, rd, v_at);
    model_end(e, 65);
    n_cmp++;
    if (frame_err !== 1'b1 || overrun !== 1'b0) begin
      n_fail++; $display("FAIL long_flags: got fe=%b ov=%b required 1 0", frame_err, overrun);
    end
    pulse_tick(v_pre, v_on, c_on, v_post);
    model_tick(ev);
    n_cmp++;
    if (v_on !== 1'b1 || c_on !== a[63:0]) begin
      n_fail++; $display("FAIL long_shadow_kept: got v=%b cfg=%h required v=1 cfg=%h", v_on, c_on, a[63:0]);
    end
  endtask

  task automatic test_random();
    logic [7:0] st; logic [15:0] rd; logic v_at, ev, v_pre, v_on, v_post; logic [63:0] c_on;
    logic [127:0] d;
    int n;
    bit co;
    for (int it = 0; it < 12; it++) begin
      d  = {$urandom, $urandom, $urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       n = 63;
        1:       n = 65;
        default: n = 64;
      endcase
      co = ($urandom_range(0, 3) == 0);
      model_start(st);
      do_frame(d, n, co, rd, v_at);
      if (co) begin
        model_tick(ev);
        n_cmp++;
        if (v_at !== ev) begin
          n_fail++; $display("FAIL rand_coincide_valid it=%0d: got %b required %b", it, v_at, ev);
        end
      end
      model_end(d, n);
      n_cmp++;
      if (rd !== {8'h00, st} || frame_err !== m_ferr || overrun !== m_ovr || cfg !== m_cfg) begin
        n_fail++;
        $display("FAIL rand_frame it=%0d n=%0d: got st=%h fe=%b ov=%b cfg=%h required st=%h fe=%b ov=%b cfg=%h",
                 it, n, rd, frame_err, overrun, cfg, {8'h00, st}, m_ferr, m_ovr, m_cfg);
      end
      if ($urandom_range(0, 1) == 1) begin
        pulse_tick(v_pre, v_on, c_on, v_post);
        model_tick(ev);
        n_cmp++;
        if ({v_pre, v_on, v_post} !== {1'b0, ev, 1'b0} || c_on !== m_cfg) begin
          n_fail++;
          $display("FAIL rand_tick it=%0d: got v=%b%b%b cfg=%h required v=0%b0 cfg=%h",
                   it, v_pre, v_on, v_post, c_on, ev, m_cfg);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_short_frame();
    test_overrun();
    test_coincide();
    test_reset_midframe();
    test_long_frame();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_config_rx.md
SPI_CONFIG_RX -- requirements
Module: spi_config_rx

Interface
REQ-001 The block SHALL have parameter FRAME_BITS, default 1024, meaning the exact number of payload bits in one valid SPI frame (at least 8).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, meaning the synchroniser depth for spi_clk, spi_mosi and spi_csn (at least 2).
REQ-003 The block SHALL have port clk, input, 1 bit: the system clock and the sole clock domain.
REQ-004 The block SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port sample_tick, input, 1 bit: a one-clk strobe per audio sample; this is the commit point.
REQ-006 The block SHALL have ports spi_clk, spi_mosi and spi_csn, inputs, 1 bit each: the asynchronous SPI mode-0 slave inputs; spi_csn is active-low.
REQ-007 The block SHALL have port spi_miso, output, 1 bit: serial status output.
REQ-008 The block SHALL have port cfg, output, FRAME_BITS wide: the committed configuration word.
REQ-009 The block SHALL have port cfg_valid, output, 1 bit: a one-clk pulse on each commit.
REQ-010 The block SHALL have port frame_err, output, 1 bit: sticky bad-length flag.
REQ-011 The block SHALL have port overrun, output, 1 bit: sticky lost-frame flag.

Function
REQ-012 All three SPI inputs SHALL pass through SYNC_STAGES flops; edges SHALL be detected on the synchronised versions only; clk ≥ 4× spi_clk is an integration requirement.
REQ-013 The FSM SHALL have states IDLE, SHIFT and CHECK; IDLE→SHIFT on a synchronised csn falling edge, clearing bitcnt.
REQ-014 In SHIFT, each synchronised spi_clk rising edge SHALL shift shift_reg right with mosi entering the MSB, so the first bit received lands in bit 0 (LSB-first).
REQ-015 bitcnt SHALL increment per received bit and saturate at FRAME_BITS+1; shifting SHALL continue past FRAME_BITS (the last FRAME_BITS bits are kept).
REQ-016 A synchronised csn rising edge in SHIFT SHALL move the FSM to CHECK, which lasts exactly one clk and then returns to IDLE.
REQ-017 In CHECK with bitcnt==FRAME_BITS, the block SHALL copy shift_reg to shadow and set pending; if pending was already 1, it SHALL set overrun (latest frame wins).
REQ-018 In CHECK with bitcnt≠FRAME_BITS (short, long or zero bits), the block SHALL set frame_err and leave shadow and pending unchanged.
REQ-019 On any clk edge with sample_tick=1 and pending=1 (pending as registered before that edge), the block SHALL load cfg←shadow, pulse cfg_valid for one cycle and clear pending.
REQ-020 If CHECK success and sample_tick coincide, the new frame SHALL NOT commit on that tick; it SHALL commit on the next tick, and the old pending frame counts as overrun.
REQ-021 Receiving SPI traffic SHALL never alter cfg outside REQ-019; cfg SHALL stay stable between commits.
REQ-022 On csn falling, the block SHALL latch status byte {5'b10100, pending, overrun, frame_err} (bit0=frame_err) into the MISO shifter and clear frame_err and overrun in the same cycle; a set event in that same cycle SHALL win.
REQ-023 spi_miso SHALL present status bit0 immediately after csn falls, advance one bit per synchronised spi_clk falling edge, output 0 after 8 bits, and be 0 while csn is high.
REQ-024 A csn rising edge seen in IDLE or CHECK SHALL be ignored; a csn falling edge seen in CHECK SHALL be taken in the following IDLE cycle.
REQ-025 Latency SHALL be: csn rising at the pin → shadow valid within SYNC_STAGES+2 clk; tick → cfg and cfg_valid on that same clk edge.

Reset
REQ-026 While rstn=0, all of the following SHALL be 0: cfg, shadow, shift_reg, bitcnt, pending, cfg_valid, frame_err, overrun, spi_miso and the synchronisers; the FSM SHALL be in IDLE.
REQ-027 Reset asserted mid-frame SHALL discard the frame; after release the block SHALL wait for a fresh csn falling edge, so a still-low csn is not treated as a frame start.

Verification (FRAME_BITS=64)
REQ-028 Bench SHALL check a 64-bit frame 0x0123456789ABCDEF sent LSB-first, then a tick → cfg=0x0123456789ABCDEF and cfg_valid high for exactly 1 clk.
REQ-029 Bench SHALL check a 63-bit frame, then a tick → frame_err=1, no cfg_valid, cfg unchanged; the next frame's status byte reads 0xA1, after which frame_err=0.
REQ-030 Bench SHALL check two valid frames A then B before any tick → overrun=1 and the tick commits B.
REQ-031 Bench SHALL check CHECK success coinciding with a tick → no commit that cycle; the frame commits on the next tick.
REQ-032 Bench SHALL check rstn pulsed after 30 bits with csn held low → all outputs 0 and no commit on later ticks until a new full frame arrives.
REQ-033 Bench SHALL check a frame with 65 bits → frame_err=1 and the shadow not updated.
